// File: rtl/postfix_eval.sv
// Stack evaluator for single-digit ASCII postfix expressions; one char per cycle, result on a done pulse.
// Define POSTFIX_EVAL_DIV_EN to accept '/' as signed truncating division.
//
// state | meaning
// IDLE  | waiting for valid; the next valid char starts a fresh expression
// ACC   | accumulating an expression; valid low closes it and pulses done
module postfix_eval #(
  parameter int W     = 16,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid,
  input  logic [7:0]   postfix,
  output logic         done,
  output logic [W-1:0] result,
  output logic         error
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [0:0] {IDLE, ACC} state_t;

  state_t         state_q, state_d;
  logic [SPW-1:0] sp_q;
  logic           err_q;
  logic [W-1:0]   stack [DEPTH];

  logic [SPW-1:0] base_sp;
  logic           base_err;
  logic [AW-1:0]  top_idx, sec_idx, push_idx;
  logic [W-1:0]   opa, opb, alu, digit;
  logic           push, pop2, set_err;

  // A new expression starts from an empty stack and a clear error, without a cycle of its own.
  assign base_sp  = (state_q == IDLE) ? '0 : sp_q;
  assign base_err = (state_q == IDLE) ? 1'b0 : err_q;

  assign top_idx  = AW'(base_sp - SPW'(1));
  assign sec_idx  = AW'(base_sp - SPW'(2));
  assign push_idx = AW'(base_sp);
  assign opb      = stack[top_idx];
  assign opa      = stack[sec_idx];
  assign digit    = {{(W-4){1'b0}}, postfix[3:0]};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid)  state_d = ACC;
      ACC:     if (!valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    push    = 1'b0;
    pop2    = 1'b0;
    set_err = 1'b0;
    alu     = '0;
    if (valid && !base_err) begin
      if (postfix >= 8'h30 && postfix <= 8'h39) begin
        if (base_sp == SPW'(DEPTH)) set_err = 1'b1;
        else                        push    = 1'b1;
      end else begin
        case (postfix)
          8'h2B: alu = opa + opb;
          8'h2D: alu = opa - opb;
          8'h2A: alu = opa * opb;
`ifdef POSTFIX_EVAL_DIV_EN
          8'h2F: alu = (opb == '0) ? '0 : W'($signed(opa) / $signed(opb));
`endif
          default: set_err = 1'b1;
        endcase
        if (!set_err) begin
          if (base_sp < SPW'(2)) set_err = 1'b1;
`ifdef POSTFIX_EVAL_DIV_EN
          else if (postfix == 8'h2F && opb == '0) set_err = 1'b1;
`endif
          else pop2 = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sp_q    <= '0;
      err_q   <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      error   <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      if (valid) begin
        err_q <= base_err | set_err;
        if (push)      sp_q <= base_sp + SPW'(1);
        else if (pop2) sp_q <= base_sp - SPW'(1);
        else           sp_q <= base_sp;
      end else if (state_q == ACC) begin
        done <= 1'b1;
        if (!err_q && sp_q == SPW'(1)) begin
          result <= stack[top_idx];
          error  <= 1'b0;
        end else begin
          result <= '0;
          error  <= 1'b1;
        end
      end
    end
  end

  // Stack contents need no reset: the pointer alone defines what is live.
  always_ff @(posedge clk) begin
    if (push)      stack[push_idx] <= digit;
    else if (pop2) stack[sec_idx]  <= alu;
  end

endmodule

// File: tb/tb_postfix_eval.sv
// Scoreboard bench for postfix_eval: expected results queued per expression, checked on done.
// Build with POSTFIX_EVAL_DIV_EN defined to cover the divide operator.
module tb_postfix_eval;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic [7:0]  postfix;
  logic        done;
  logic [15:0] result;
  logic        error;

  int n_tests = 0;
  int n_fail  = 0;
  logic [16:0] exp_q [$];
  logic prev_done = 1'b0;

  postfix_eval #(.W(16), .DEPTH(16)) dut (
    .clk(clk), .reset(reset), .valid(valid), .postfix(postfix),
    .done(done), .result(result), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard side: every done must match the oldest outstanding expression.
  always @(negedge clk) begin
    if (done) begin
      chk("done_pulse_width", {31'd0, prev_done}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        chk("error", {31'd0, error}, {31'd0, e[16]});
        chk("result", {16'd0, result}, {16'd0, e[15:0]});
      end
    end
    prev_done = done;
  end

  task automatic send(input string s, input logic exp_err, input logic [15:0] exp_res);
    exp_q.push_back({exp_err, exp_res});
    for (int i = 0; i < s.len(); i++) begin
      valid   = 1'b1;
      postfix = s[i];
      @(posedge clk); #1;
    end
    valid = 1'b0;
    @(posedge clk); #1;
    chk("done_latency", {31'd0, done}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    string s;
    reset   = 1'b1;
    valid   = 1'b0;
    postfix = 8'h00;
    #1;
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    send("34+", 1'b0, 16'd7);
    send("93-2*", 1'b0, 16'd12);
    send("12-", 1'b0, 16'hFFFF);
    send("9", 1'b0, 16'd9);
    send("+", 1'b1, 16'd0);
    send("12", 1'b1, 16'd0);
    send("3a", 1'b1, 16'd0);

    s = "";
    for (int i = 0; i < 17; i++) s = {s, "9"};
    send(s, 1'b1, 16'd0);

    s = "";
    for (int i = 0; i < 16; i++) s = {s, "9"};
    for (int i = 0; i < 15; i++) s = {s, "+"};
    send(s, 1'b0, 16'd144);

`ifdef POSTFIX_EVAL_DIV_EN
    send("82/", 1'b0, 16'd4);
    send("07-2/", 1'b0, 16'hFFFD);
    send("30/", 1'b1, 16'd0);
`else
    send("82/", 1'b1, 16'd0);
`endif
    send("99*7-", 1'b0, 16'd74);

    // Reset asserted on the 2nd char of "345**": outputs clear immediately, no done follows.
    valid   = 1'b1;
    postfix = "3";
    @(posedge clk); #1;
    postfix = "4";
    reset   = 1'b1;
    #1;
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_result", {16'd0, result}, 32'd0);
    chk("midrst_error", {31'd0, error}, 32'd0);
    @(posedge clk); #1;
    valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send("22*", 1'b0, 16'd4);

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/postfix_eval.md
# postfix_eval

Stack-based evaluator for the single-digit ASCII postfix stream produced by the infix-to-postfix converter. Sits directly downstream: its `valid`/`postfix` inputs connect to the converter's `ready`/`postfix` outputs. It emits one signed result per expression with a one-cycle `done` pulse and an `error` flag.

## Interface
- `W`, 16: data width of stack entries and `result` (two's complement).
- `DEPTH`, 16: operand stack depth, entries (≥2).

- `clk`  input  1  clock; all state on rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `valid`  input  1  high for every cycle of one contiguous expression; low between expressions.
- `postfix`  input  8  ASCII character, sampled when `valid`=1.
- `done`  output  1  one-cycle pulse: `result`/`error` valid.
- `result`  output  W  expression value; held until next `done`.
- `error`  output  1  expression malformed; held until next `done`.

## Operation
- States: IDLE, ACC.
- IDLE, `valid`=1: clear stack pointer and sticky error, process char, go to ACC. IDLE, `valid`=0: stay.
- ACC, `valid`=1: process char. ACC, `valid`=0: register outputs, pulse `done`, go to IDLE.
- Processing one char per cycle, no stall:
  - '0'–'9' (0x30–0x39): push zero-extended digit value. Push when depth = DEPTH → overflow error.
  - '+', '-', '*': pop b (top), pop a, push a op b. '-' is a−b. Fewer than 2 entries → underflow error.
  - Arithmetic is W-bit two's complement, wraps silently; '*' keeps low W bits of the product.
  - Any other code → illegal-char error.
- Error is sticky per expression: once set, remaining chars are ignored (stack frozen).
- At end (ACC, `valid`=0): if no error and depth = 1 → `result`=top, `error`=0; otherwise `result`=0, `error`=1 (includes depth 0 or >1).

## Timing
- Reset values: `done`=0, `result`=0, `error`=0, state IDLE, depth 0. Reset is asynchronous; assertion immediately forces these values.
- Chars sampled at edges 1..N (`valid`=1), first low sample at edge N+1 → `done`=1 from edge N+1 to N+2; latency = 1 cycle after `valid` falls.
- `done` is never high for two consecutive cycles.
- A new expression can start at edge N+2 (when `done` falls); no dead cycle is required beyond the `valid`-low cycle.
- Reset mid-expression: expression abandoned, no `done`. If `reset` releases while `valid`=1, the remaining tail is evaluated as a new expression.
- Single-char expression (N=1): `done` at edge 2.

## Configuration
- `POSTFIX_EVAL_DIV_EN` defined: '/' (0x2F) is an operator. It computes a/b as signed division truncating toward zero. b = 0 → error, `result`=0.
- Not defined: '/' is an illegal char → `error`=1. No divider logic is synthesized.

## Test plan
- Stream "34+" (0x33,0x34,0x2B) then `valid` low → `done` pulse 1 cycle after fall, `result`=7, `error`=0.
- "93-2*" → `result`=12. Then back-to-back "12-" starting the cycle `done` falls → `result`=0xFFFF (−1), `error`=0.
- "+" → underflow, `result`=0, `error`=1. "12" → depth 2 at end, `error`=1. "3a" → illegal char, `error`=1.
- 17 × '9' with DEPTH=16 → overflow, `error`=1. 16 × '9' then 15 × '+' → `result`=144, `error`=0.
- Assert `reset` at 2nd char of "345**" → `done`/`result`/`error` immediately 0. Release between expressions, then send "22*" → `result`=4.
- With `POSTFIX_EVAL_DIV_EN`: "82/" → 4; "07-2/" → −3 (0xFFFD); "30/" → `error`=1. Without the macro: "82/" → `error`=1.
